// File: rtl/hram_chan_arbiter_if.sv
// Requester and controller bundle for the HyperRAM channel arbiter.
// The arbiter binds the slave modport; the environment binds the master modport.
interface hram_chan_arbiter_if;
    logic [1:0]  req_valid;
    logic [3:0]  req_mode;
    logic [63:0] req_addr;
    logic [63:0] req_num_words;
    logic [5:0]  req_latency;
    logic [63:0] req_wr_data;
    logic [1:0]  req_wr_valid;
    logic [1:0]  req_gnt;
    logic [1:0]  req_done;
    logic [1:0]  req_err;
    logic [31:0] rd_data;
    logic [1:0]  rd_valid;
    logic        busy;

    logic        ctrl_ready;
    logic        ctrl_cs;
    logic [1:0]  ctrl_mode;
    logic [31:0] ctrl_addr;
    logic [31:0] ctrl_num_words;
    logic [2:0]  ctrl_latency;
    logic [31:0] ctrl_wr_data;
    logic        ctrl_wr_data_valid;
    logic [31:0] ctrl_rd_data;
    logic        ctrl_rd_data_valid;

    modport slave (
        input  req_valid, req_mode, req_addr, req_num_words, req_latency,
               req_wr_data, req_wr_valid, ctrl_ready, ctrl_rd_data, ctrl_rd_data_valid,
        output req_gnt, req_done, req_err, rd_data, rd_valid, busy,
               ctrl_cs, ctrl_mode, ctrl_addr, ctrl_num_words, ctrl_latency,
               ctrl_wr_data, ctrl_wr_data_valid
    );

    modport master (
        output req_valid, req_mode, req_addr, req_num_words, req_latency,
               req_wr_data, req_wr_valid, ctrl_ready, ctrl_rd_data, ctrl_rd_data_valid,
        input  req_gnt, req_done, req_err, rd_data, rd_valid, busy,
               ctrl_cs, ctrl_mode, ctrl_addr, ctrl_num_words, ctrl_latency,
               ctrl_wr_data, ctrl_wr_data_valid
    );
endinterface

// File: rtl/hram_chan_arbiter.sv
// Two-requester round-robin arbiter in front of a HyperRAM controller.
// Optional read watchdog enabled by defining HRAM_ARB_TIMEOUT_EN.
module hram_chan_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    hram_chan_arbiter_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef HRAM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic [2:0]       state_q, state_d;
    logic             sel_q, sel_d;
    logic             prio_q, prio_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      num_q, num_d;
    logic [2:0]       lat_q, lat_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic             wr_vld_q, wr_vld_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic [1:0]       rd_vld_q, rd_vld_d;

    // prio_q names the requester that wins a tie; it flips to the other one after each DONE.
    logic        win;
    logic [31:0] win_num;
    assign win     = bus.req_valid[prio_q] ? prio_q : ~prio_q;
    assign win_num = win ? bus.req_num_words[63:32] : bus.req_num_words[31:0];

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        sel_d     = sel_q;
        prio_d    = prio_q;
        gnt_d     = gnt_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        num_d     = num_q;
        lat_d     = lat_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        wr_data_d = wr_data_q;
        wr_vld_d  = 1'b0;
        rd_data_d = rd_data_q;
        rd_vld_d  = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (bus.ctrl_ready && (bus.req_valid != 2'b00)) begin
                    sel_d   = win;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    mode_d  = win ? bus.req_mode[3:2] : bus.req_mode[1:0];
                    addr_d  = win ? bus.req_addr[63:32] : bus.req_addr[31:0];
                    num_d   = win_num;
                    lat_d   = win ? bus.req_latency[5:3] : bus.req_latency[2:0];
                    cnt_d   = '0;
                    state_d = (win_num == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                tmo_d   = '0;
                state_d = mode_q[0] ? S_READ : S_WRITE;
            end
            S_WRITE: begin
                if (cnt_q == num_q) begin
                    state_d = S_DONE;
                end else if (bus.req_wr_valid[sel_q]) begin
                    wr_vld_d  = 1'b1;
                    wr_data_d = sel_q ? bus.req_wr_data[63:32] : bus.req_wr_data[31:0];
                    cnt_d     = cnt_q + 32'd1;
                end
            end
            S_READ: begin
                if (cnt_q == num_q) begin
                    state_d = S_DONE;
                end else if (bus.ctrl_rd_data_valid) begin
                    rd_vld_d  = gnt_q;
                    rd_data_d = bus.ctrl_rd_data;
                    cnt_d     = cnt_q + 32'd1;
                    tmo_d     = '0;
                end else if (TMO_EN) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                gnt_d   = 2'b00;
                err_d   = 1'b0;
                prio_d  = ~sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            prio_q    <= 1'b0;
            gnt_q     <= 2'b00;
            mode_q    <= '0;
            addr_q    <= '0;
            num_q     <= '0;
            lat_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            wr_data_q <= '0;
            wr_vld_q  <= 1'b0;
            rd_data_q <= '0;
            rd_vld_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            prio_q    <= prio_d;
            gnt_q     <= gnt_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            num_q     <= num_d;
            lat_q     <= lat_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            wr_data_q <= wr_data_d;
            wr_vld_q  <= wr_vld_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    logic [1:0] done_w;
    assign done_w = (state_q == S_DONE) ? gnt_q : 2'b00;

    assign bus.req_gnt            = gnt_q;
    assign bus.req_done           = done_w;
    assign bus.req_err            = (TMO_EN && err_q) ? done_w : 2'b00;
    assign bus.rd_data            = rd_data_q;
    assign bus.rd_valid           = rd_vld_q;
    assign bus.busy               = (state_q != S_IDLE);
    assign bus.ctrl_cs            = (state_q == S_ISSUE);
    assign bus.ctrl_mode          = mode_q;
    assign bus.ctrl_addr          = addr_q;
    assign bus.ctrl_num_words     = num_q;
    assign bus.ctrl_latency       = lat_q;
    assign bus.ctrl_wr_data       = wr_data_q;
    assign bus.ctrl_wr_data_valid = wr_vld_q;

endmodule

// File: tb/tb_hram_chan_arbiter.sv
// Self-checking bench for hram_chan_arbiter: transaction-level model plus directed scenarios.
// Build with HRAM_ARB_TIMEOUT_EN defined to exercise the read watchdog (TIMEOUT_CYCLES=8).
`timescale 1ns/1ps
module tb_hram_chan_arbiter;

    localparam int unsigned TMO = 8;
`ifdef HRAM_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hram_chan_arbiter_if bus ();
    hram_chan_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef enum int {P_IDLE, P_ISSUE, P_WRITE, P_READ, P_DONE} phase_t;
    typedef struct {
        phase_t          phase;
        bit              who;
        bit              prio;
        bit              gnt;
        logic [1:0]      mode;
        logic [31:0]     addr;
        logic [31:0]     num;
        logic [2:0]      lat;
        longint unsigned moved;
        int              quiet;
        bit              err;
        bit              wv;
        logic [31:0]     wd;
        bit              rv;
        logic [31:0]     rd;
    } model_t;

    function automatic model_t model_reset();
        model_t r;
        r.phase = P_IDLE; r.who = 0; r.prio = 0; r.gnt = 0;
        r.mode = '0; r.addr = '0; r.num = '0; r.lat = '0;
        r.moved = 0; r.quiet = 0; r.err = 0;
        r.wv = 0; r.wd = '0; r.rv = 0; r.rd = '0;
        return r;
    endfunction

    function automatic logic [31:0] lane(input logic [63:0] v, input bit i);
        return i ? v[63:32] : v[31:0];
    endfunction

    function automatic logic [1:0] onehot(input bit w);
        return w ? 2'b10 : 2'b01;
    endfunction

    function automatic model_t step(input model_t s);
        model_t n = s;
        n.wv = 0;
        n.rv = 0;
        case (s.phase)
            P_IDLE: if (bus.ctrl_ready && bus.req_valid != 2'b00) begin
                n.who   = bus.req_valid[s.prio] ? s.prio : !s.prio;
                n.mode  = n.who ? bus.req_mode[3:2] : bus.req_mode[1:0];
                n.lat   = n.who ? bus.req_latency[5:3] : bus.req_latency[2:0];
                n.addr  = lane(bus.req_addr, n.who);
                n.num   = lane(bus.req_num_words, n.who);
                n.gnt   = 1;
                n.moved = 0;
                n.phase = (n.num == 0) ? P_DONE : P_ISSUE;
            end
            P_ISSUE: begin
                n.moved = 0;
                n.quiet = 0;
                n.phase = s.mode[0] ? P_READ : P_WRITE;
            end
            P_WRITE: begin
                if (s.moved == longint'(s.num)) n.phase = P_DONE;
                else if (bus.req_wr_valid[s.who]) begin
                    n.wv = 1;
                    n.wd = lane(bus.req_wr_data, s.who);
                    n.moved = s.moved + 1;
                end
            end
            P_READ: begin
                if (s.moved == longint'(s.num)) n.phase = P_DONE;
                else if (bus.ctrl_rd_data_valid) begin
                    n.rv = 1;
                    n.rd = bus.ctrl_rd_data;
                    n.moved = s.moved + 1;
                    n.quiet = 0;
                end else if (TMO_ON) begin
                    n.quiet = s.quiet + 1;
                    if (n.quiet >= int'(TMO)) begin
                        n.phase = P_DONE;
                        n.err = 1;
                    end
                end
            end
            P_DONE: begin
                n.gnt = 0;
                n.err = 0;
                n.prio = !s.who;
                n.phase = P_IDLE;
            end
            default: n.phase = P_IDLE;
        endcase
        return n;
    endfunction

    model_t m;
    always @(posedge clk or negedge rst) begin
        if (!rst) m <= model_reset();
        else      m <= step(m);
    end

    function automatic logic [1:0] exp_gnt(input model_t s);
        return s.gnt ? onehot(s.who) : 2'b00;
    endfunction
    function automatic logic [1:0] exp_done(input model_t s);
        return (s.phase == P_DONE) ? onehot(s.who) : 2'b00;
    endfunction

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            check("gnt",      bus.req_gnt, exp_gnt(m));
            check("done",     bus.req_done, exp_done(m));
            check("err",      bus.req_err, m.err ? exp_done(m) : 2'b00);
            check("busy",     bus.busy, m.phase != P_IDLE);
            check("cs",       bus.ctrl_cs, m.phase == P_ISSUE);
            check("cmd_mode", bus.ctrl_mode, m.mode);
            check("cmd_addr", bus.ctrl_addr, m.addr);
            check("cmd_num",  bus.ctrl_num_words, m.num);
            check("cmd_lat",  bus.ctrl_latency, m.lat);
            check("wr_vld",   bus.ctrl_wr_data_valid, m.wv);
            if (m.wv) check("wr_data", bus.ctrl_wr_data, m.wd);
            check("rd_vld",   bus.rd_valid, m.rv ? onehot(m.who) : 2'b00);
            if (m.rv) check("rd_data", bus.rd_data, m.rd);
            check("rd_vld_ungranted", bus.rd_valid & ~bus.req_gnt, 2'b00);
        end
    end

    // ---------------- stimulus ----------------
    bit rd_auto = 0, ready_rand = 0, wr_rand = 0, req_auto = 0, req_new = 0;
    int n_cs = 0, n_wbeat = 0, n_rdv = 0, n_done = 0, n_rd_bad = 0;
    int done_q[$];

    task automatic tick();
        @(negedge clk);
        if (bus.ctrl_cs) n_cs++;
        if (bus.ctrl_wr_data_valid) n_wbeat++;
        if (bus.rd_valid != 2'b00) n_rdv++;
        if ((bus.rd_valid & ~bus.req_gnt) != 2'b00) n_rd_bad++;
        if (bus.req_done != 2'b00) begin
            n_done++;
            done_q.push_back(bus.req_done == 2'b10 ? 1 : 0);
        end
        bus.ctrl_rd_data_valid = rd_auto ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.ctrl_rd_data = $urandom;
        if (ready_rand) bus.ctrl_ready = ($urandom_range(0, 3) != 0);
        if (wr_rand) begin
            bus.req_wr_valid = 2'($urandom_range(0, 3));
            bus.req_wr_data  = {$urandom, $urandom};
        end
        if (req_auto) begin
            for (int r = 0; r < 2; r++) begin
                if (!bus.req_valid[r]) begin
                    if (req_new && $urandom_range(0, 3) == 0) begin
                        bus.req_mode[r*2 +: 2]        = 2'($urandom_range(0, 3));
                        bus.req_addr[r*32 +: 32]      = $urandom;
                        bus.req_num_words[r*32 +: 32] = $urandom_range(0, 6);
                        bus.req_latency[r*3 +: 3]     = 3'($urandom_range(0, 7));
                        bus.req_valid[r]              = 1'b1;
                    end
                end else if (m.phase == P_DONE && m.who == 1'(r)) begin
                    bus.req_valid[r] = 1'b0;
                end else if (m.gnt && m.who == 1'(r) && $urandom_range(0, 15) == 0) begin
                    bus.req_valid[r] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_done(input int budget, output logic [1:0] d);
        d = 2'b00;
        for (int i = 0; i < budget && d == 2'b00; i++) begin
            tick();
            d = bus.req_done;
        end
    endtask

    task automatic wait_cs(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = bus.ctrl_cs;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int         base_cs, base_wb, base_rdv, base_done;
        int         exp_order[4];
        logic [1:0] d;
        bit         seen;

        bus.req_valid = '0; bus.req_mode = '0; bus.req_addr = '0; bus.req_num_words = '0;
        bus.req_latency = '0; bus.req_wr_data = '0; bus.req_wr_valid = '0;
        bus.ctrl_ready = 1'b1; bus.ctrl_rd_data = '0; bus.ctrl_rd_data_valid = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_flags", {bus.req_gnt, bus.req_done, bus.req_err, bus.rd_valid,
                            bus.busy, bus.ctrl_cs, bus.ctrl_wr_data_valid}, '0);
        check("rst_cmd", {bus.ctrl_addr, bus.ctrl_num_words}, '0);
        check("rst_data", {bus.rd_data, bus.ctrl_wr_data}, '0);
        rst = 1'b1;

        // Both requesters hold 2-word reads: grants must alternate starting at 0.
        done_q.delete();
        base_rd_bad_reset();
        bus.req_mode = 4'b0101;
        bus.req_addr = {32'h2000, 32'h1000};
        bus.req_num_words = {32'd2, 32'd2};
        bus.req_valid = 2'b11;
        rd_auto = 1;
        for (int i = 0; i < 400 && done_q.size() < 4; i++) tick();
        bus.req_valid = 2'b00;
        exp_order = '{0, 1, 0, 1};
        check("rr_count", done_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), done_q[i], exp_order[i]);
        check("rr_rd_vld_ungranted", n_rd_bad, 0);
        tick();

        // Requester 0 writes 4 words at 0x100.
        base_cs = n_cs; base_wb = n_wbeat;
        bus.req_mode = 4'b0000;
        bus.req_addr[31:0] = 32'h100;
        bus.req_num_words[31:0] = 32'd4;
        bus.req_latency[2:0] = 3'd3;
        bus.req_valid = 2'b01;
        wait_cs(20, seen);
        check("wr_cs_seen", seen, 1);
        check("wr_addr", bus.ctrl_addr, 32'h100);
        check("wr_num", bus.ctrl_num_words, 32'd4);
        check("wr_lat", bus.ctrl_latency, 3'd3);
        tick();
        bus.req_wr_valid = 2'b11;
        bus.req_wr_data = {32'hDEAD_0000, 32'hA000};
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("wr_beat%0d_vld", i - 1), bus.ctrl_wr_data_valid, 1);
            check($sformatf("wr_beat%0d_data", i - 1), bus.ctrl_wr_data, 32'hA000 + 32'(i - 1));
            if (i < 4) bus.req_wr_data = {32'hDEAD_0000 + 32'(i), 32'hA000 + 32'(i)};
            else       bus.req_wr_valid = 2'b00;
        end
        tick();
        check("wr_done", bus.req_done, 2'b01);
        check("wr_no_extra_beat", bus.ctrl_wr_data_valid, 0);
        bus.req_valid = 2'b00;
        check("wr_cs_count", n_cs - base_cs, 1);
        check("wr_beat_count", n_wbeat - base_wb, 4);
        tick();

        // Zero-length write: completion without cs or beats.
        base_cs = n_cs; base_wb = n_wbeat;
        bus.req_num_words[31:0] = 32'd0;
        bus.req_valid = 2'b01;
        wr_rand = 1;
        wait_done(20, d);
        bus.req_valid = 2'b00;
        check("zl_done", d, 2'b01);
        wr_rand = 0;
        bus.req_wr_valid = 2'b00;
        tick();
        check("zl_cs_count", n_cs - base_cs, 0);
        check("zl_beat_count", n_wbeat - base_wb, 0);

        // Reset during a 16-word read by requester 1 after word 5.
        base_rdv = n_rdv; base_done = n_done;
        bus.req_mode[3:2] = 2'b01;
        bus.req_num_words[63:32] = 32'd16;
        bus.req_valid = 2'b10;
        for (int i = 0; i < 300 && (n_rdv - base_rdv) < 5; i++) tick();
        check("rst_mid_words", n_rdv - base_rdv, 5);
        rst = 1'b0;
        #1;
        check("rst_mid_flags", {bus.req_gnt, bus.req_done, bus.req_err, bus.rd_valid,
                                bus.busy, bus.ctrl_cs, bus.ctrl_wr_data_valid}, '0);
        check("rst_mid_cmd", {bus.ctrl_addr, bus.ctrl_num_words}, '0);
        check("rst_mid_data", {bus.rd_data, bus.ctrl_wr_data}, '0);
        check("rst_mid_mode", {bus.ctrl_mode, bus.ctrl_latency}, '0);
        repeat (3) tick();
        check("rst_mid_no_done", n_done - base_done, 0);
        bus.req_mode = 4'b0101;
        bus.req_num_words = {32'd1, 32'd1};
        bus.req_valid = 2'b11;
        rst = 1'b1;
        d = 2'b00;
        for (int i = 0; i < 20 && d == 2'b00; i++) begin
            tick();
            d = bus.req_gnt;
        end
        check("rst_next_gnt", d, 2'b01);
        wait_done(100, d);
        bus.req_valid = 2'b00;
        check("rst_next_done", d, 2'b01);
        tick();

        // Randomized traffic against the model.
        base_done = n_done;
        rd_auto = 1; ready_rand = 1; wr_rand = 1; req_auto = 1; req_new = 1;
        repeat (4000) tick();
        req_new = 0;
        for (int i = 0; i < 2000 && !(bus.req_valid == 2'b00 && m.phase == P_IDLE); i++) tick();
        check("rand_drained", (bus.req_valid == 2'b00) && (m.phase == P_IDLE), 1);
        check("rand_activity", (n_done - base_done) > 50, 1);
        req_auto = 0; wr_rand = 0; ready_rand = 0;
        bus.req_wr_valid = 2'b00;
        bus.ctrl_ready = 1'b1;
        rd_auto = 0;
        tick();

        // Read that never receives data.
        bus.req_mode[1:0] = 2'b01;
        bus.req_num_words[31:0] = 32'd3;
        bus.req_valid = 2'b01;
        wait_cs(20, seen);
        check("stall_cs_seen", seen, 1);
`ifdef HRAM_ARB_TIMEOUT_EN
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k < 9) check($sformatf("tmo_not_yet%0d", k), bus.req_done, 2'b00);
        end
        check("tmo_done", bus.req_done, 2'b01);
        check("tmo_err", bus.req_err, 2'b01);
        bus.req_valid = 2'b00;
        tick();
        check("tmo_idle", bus.busy, 0);
`else
        repeat (30) tick();
        check("stall_waiting", {bus.busy, bus.req_done}, 3'b100);
        rd_auto = 1;
        wait_done(200, d);
        bus.req_valid = 2'b00;
        check("stall_done", d, 2'b01);
        check("stall_no_err", bus.req_err, 2'b00);
        rd_auto = 0;
        tick();
        check("stall_idle", bus.busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic base_rd_bad_reset();
        n_rd_bad = 0;
    endtask

endmodule

// File: doc/hram_chan_arbiter.md
HRAM_CHAN_ARBITER -- requirements
Module: hram_chan_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 TIMEOUT_CYCLES, 1024, read-watchdog limit in clk cycles; only used when HRAM_ARB_TIMEOUT_EN is defined.
Ports (name, direction, width, meaning):
REQ-002 clk  input  1  single clock for all logic (200 MHz controller domain).
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester transaction request, level-held until req_done.
REQ-005 req_mode  input  4  2 bits per requester; bit0=1 read, bit0=0 write.
REQ-006 req_addr  input  64  32 bits per requester, start address.
REQ-007 req_num_words  input  64  32 bits per requester, burst length in 32-bit words.
REQ-008 req_latency  input  6  3 bits per requester, HyperRAM latency code.
REQ-009 req_wr_data  input  64  32 bits per requester, write word.
REQ-010 req_wr_valid  input  2  per-requester write-word strobe, one word per cycle.
REQ-011 req_gnt  output  2  one-hot grant, held for the whole transaction.
REQ-012 req_done  output  2  one-cycle completion pulse to the granted requester.
REQ-013 req_err  output  2  one-cycle abort pulse, coincident with req_done.
REQ-014 rd_data  output  32  read word, broadcast to both requesters.
REQ-015 rd_valid  output  2  read-word strobe, asserted only on the granted requester's bit.
REQ-016 busy  output  1  high whenever the FSM is not IDLE.
REQ-017 ctrl_ready  input  1  controller ready.
REQ-018 ctrl_cs  output  1  one-cycle start pulse to the controller.
REQ-019 ctrl_mode / ctrl_addr / ctrl_num_words / ctrl_latency  output  2/32/32/3  registered command fields of the granted requester.
REQ-020 ctrl_wr_data / ctrl_wr_data_valid  output  32/1  registered write stream to the controller.
REQ-021 ctrl_rd_data / ctrl_rd_data_valid  input  32/1  read stream from the controller.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, WRITE, READ and DONE.
REQ-023 Arbitration (IDLE only):
- IDLE SHALL sample requests only when ctrl_ready=1.
- Arbitration SHALL be round-robin: last-served requester has lowest priority; requester 0 has priority after reset.
- With both requests valid, the two requesters SHALL alternate.
REQ-024 Grant: on grant, the FSM SHALL register the winner's command fields, set req_gnt one-hot on the next cycle, and go to ISSUE.
REQ-025 Zero-length burst: if the winner's num_words==0, the FSM SHALL go straight to DONE with no ctrl_cs pulse.
REQ-026 ISSUE SHALL pulse ctrl_cs for exactly one cycle, clear the 32-bit word counter, then go to READ (mode bit0=1) or WRITE.
REQ-027 WRITE:
- Each granted req_wr_valid SHALL be forwarded to ctrl_wr_data/ctrl_wr_data_valid with one cycle of latency and SHALL increment the counter.
- When counter==num_words, the FSM SHALL go to DONE.
- req_wr_valid beyond num_words, and any req_wr_valid from the non-granted requester, SHALL be ignored.
REQ-028 READ:
- Each ctrl_rd_data_valid SHALL drive rd_data and the granted rd_valid bit one cycle later, and SHALL increment the counter.
- When counter==num_words, the FSM SHALL go to DONE.
- ctrl_rd_data_valid received in any other state SHALL be dropped.
REQ-029 DONE SHALL pulse req_done on the granted bit for one cycle, clear req_gnt in the same cycle, update the round-robin pointer, and return to IDLE.
REQ-030 Mid-transaction: deassertion of req_valid SHALL NOT abort the transaction.
REQ-031 Counter: the counter SHALL be 32 bits and SHALL NOT wrap; num_words=0xFFFFFFFF is legal.

Reset
REQ-032 While rst=0, all outputs, the FSM state (IDLE), the counter and the round-robin pointer (requester 0) SHALL be 0 asynchronously.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction with no req_done pulse.
REQ-034 Operation SHALL resume on the first clk edge after rst deasserts.

Configuration
REQ-035 Macro HRAM_ARB_TIMEOUT_EN:
- Defined: in READ, TIMEOUT_CYCLES consecutive cycles without ctrl_rd_data_valid SHALL force DONE with req_err and req_done pulsed together.
- Undefined: READ SHALL wait indefinitely, and req_err SHALL be tied to 0.

Verification
REQ-036 Requester 0 writes 4 words at addr 0x100:
- Expect one ctrl_cs pulse, ctrl_addr=0x100, ctrl_num_words=4.
- Expect 4 ctrl_wr_data_valid beats, each one cycle after its req_wr_valid.
- Expect req_done[0] one cycle after the 4th beat.
REQ-037 Both requesters hold req_valid, each issuing 2-word reads, for 4 transactions:
- Expect grant order 0,1,0,1.
- rd_valid SHALL never assert on the non-granted bit.
REQ-038 num_words=0 write: expect req_done with no ctrl_cs and no ctrl_wr_data_valid.
REQ-039 rst pulsed low during a 16-word read after word 5: expect all outputs 0 immediately, no req_done, and the next request granted to requester 0.
REQ-040 With HRAM_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, a read with no ctrl_rd_data_valid: expect req_err and req_done 8 cycles after entering READ, then busy=0.
